// File: rtl/xorshift128_pkg.sv
// rtl/xorshift128_pkg.sv - xorshift128 seed constants, checker FSM encoding and next-word function
package xorshift128_pkg;

    localparam logic [31:0] X0 = 32'd123456789;
    localparam logic [31:0] Y0 = 32'd362436069;
    localparam logic [31:0] Z0 = 32'd521288629;
    localparam logic [31:0] W0 = 32'd88675123;

    typedef enum logic [1:0] {
        ST_ACQ    = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } fsm_t;

    function automatic logic [31:0] xs128_next_w(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] z,
        input logic [31:0] w
    );
        logic [31:0] t0;
        logic [31:0] t1;
        logic [31:0] unused_yz;
        unused_yz = y ^ z;
        t0 = x ^ (x << 11);
        t1 = t0 ^ (t0 >> 8);
        xs128_next_w = t1 ^ w ^ (w >> 19) ^ (unused_yz & 32'd0);
    endfunction

endpackage

// File: rtl/xorshift128_next.sv
// rtl/xorshift128_next.sv - combinational xorshift128 state to next generator word
module xorshift128_next
    import xorshift128_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] z,
    input  logic [31:0] w,
    output logic [31:0] next_w
);

    assign next_w = xs128_next_w(x, y, z, w);

endmodule

// File: rtl/xorshift128_checker.sv
// rtl/xorshift128_checker.sv - xorshift128 stream checker: acquire, verify, lock, count errors
// Optional macro XS128_CHK_RESEED_EN adds seed/re_seed for reseed-driven acquisition.
module xorshift128_checker
    import xorshift128_pkg::*;
#(
    parameter int LOCK_GOOD   = 8,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [31:0]          in_data,
    input  logic                 clear,
`ifdef XS128_CHK_RESEED_EN
    input  logic [31:0]          seed,
    input  logic                 re_seed,
`endif
    output logic                 locked,
    output logic [1:0]           fsm_state,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [31:0]          word_cnt
);

    localparam int MW  = (LOCK_GOOD > 1) ? $clog2(LOCK_GOOD) : 1;
    localparam int LW  = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH) : 1;
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_GOOD - 1);
    localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_THRESH - 1);

    fsm_t state, state_nxt;
    logic [31:0] x, y, z, w;
    logic [31:0] x_nxt, y_nxt, z_nxt, w_nxt;
    logic [31:0] p;
    logic        hit;
    logic [1:0]  fill, fill_nxt;
    logic [MW-1:0] match_cnt, match_nxt;
    logic [LW-1:0] miss_cnt, miss_nxt;
    logic        err_nxt;
    logic [ERR_CNT_W-1:0] err_cnt_nxt;
    logic [31:0] word_cnt_nxt;

    xorshift128_next u_next (
        .x      (x),
        .y      (y),
        .z      (z),
        .w      (w),
        .next_w (p)
    );

    assign hit = (in_data == p);

    always_comb begin
        state_nxt    = state;
        fill_nxt     = fill;
        match_nxt    = match_cnt;
        miss_nxt     = miss_cnt;
        x_nxt        = x;
        y_nxt        = y;
        z_nxt        = z;
        w_nxt        = w;
        err_nxt      = 1'b0;
        err_cnt_nxt  = err_cnt;
        word_cnt_nxt = word_cnt;
`ifdef XS128_CHK_RESEED_EN
        if (re_seed) begin
            x_nxt     = seed;
            y_nxt     = Y0;
            z_nxt     = Z0;
            w_nxt     = W0;
            state_nxt = ST_VERIFY;
            match_nxt = '0;
        end else
`endif
        if (in_valid) begin
            case (state)
                ST_ACQ: begin
                    {x_nxt, y_nxt, z_nxt, w_nxt} = {y, z, w, in_data};
                    if (fill == 2'd3) begin
                        state_nxt = ST_VERIFY;
                        fill_nxt  = 2'd0;
                        match_nxt = '0;
                    end else begin
                        fill_nxt = fill + 2'd1;
                    end
                end
                ST_VERIFY: begin
                    if (hit) begin
                        {x_nxt, y_nxt, z_nxt, w_nxt} = {y, z, w, p};
                        if (match_cnt == MATCH_LAST) begin
                            state_nxt = ST_LOCKED;
                            miss_nxt  = '0;
                        end else begin
                            match_nxt = match_cnt + 1'b1;
                        end
                    end else begin
                        // restart acquisition with the offending word as the first fill
                        {x_nxt, y_nxt, z_nxt, w_nxt} = {y, z, w, in_data};
                        state_nxt = ST_ACQ;
                        fill_nxt  = 2'd1;
                    end
                end
                ST_LOCKED: begin
                    // predictor free-runs so a corrupted sample never enters the state
                    {x_nxt, y_nxt, z_nxt, w_nxt} = {y, z, w, p};
                    word_cnt_nxt = (&word_cnt) ? word_cnt : word_cnt + 32'd1;
                    if (hit) begin
                        miss_nxt = '0;
                    end else begin
                        err_nxt     = 1'b1;
                        err_cnt_nxt = (&err_cnt) ? err_cnt : err_cnt + 1'b1;
                        if (miss_cnt == MISS_LAST) begin
                            state_nxt = ST_ACQ;
                            fill_nxt  = 2'd0;
                            miss_nxt  = '0;
                        end else begin
                            miss_nxt = miss_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_ACQ;
                    fill_nxt  = 2'd0;
                end
            endcase
        end
        if (clear) begin
            err_cnt_nxt  = '0;
            word_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACQ;
            fill      <= 2'd0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            w         <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            word_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            fill      <= fill_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            x         <= x_nxt;
            y         <= y_nxt;
            z         <= z_nxt;
            w         <= w_nxt;
            locked    <= (state_nxt == ST_LOCKED);
            err_pulse <= err_nxt;
            err_cnt   <= err_cnt_nxt;
            word_cnt  <= word_cnt_nxt;
        end
    end

    assign fsm_state = state;

endmodule
